pdm_modulator: RTL and testbench

PDM_MODULATOR -- requirements
Module: pdm_modulator

---
 rtl/pdm_modulator.sv | 143 ++++++++++++++
 tb/tb_pdm_modulator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
// Purpose: first-order sigma-delta PDM modulator with linear interpolation between successive samples.
// Latency: a sample accepted in frame n ramps during frame n+1; the first PDM bit appears one edge after entering RUN.
// Backpressure: a one-entry buffer; in_ready drops while it is full and rises again when a frame boundary consumes it.
module pdm_modulator #(
  parameter int WIDTH  = 8,
  parameter int INTERP = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pdm_out,
  output logic             frame_tick,
  output logic             busy,
  output logic             underrun
);

  localparam int L  = $clog2(INTERP);
  localparam int VW = WIDTH + L;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [WIDTH-1:0]        s_cur_q, s_cur_d;
  logic [VW-1:0]           v_q, v_d;
  logic signed [WIDTH:0]   delta_q, delta_d;
  logic [VW-1:0]           sd_acc_q, sd_acc_d;
  logic [L-1:0]            cnt_q, cnt_d;
  logic                    pdm_q, pdm_d;
  logic                    underrun_q, underrun_d;

  // Datapath helpers: the accumulator carry-out is the PDM bit, since both operands are below 2^VW.
  logic [VW:0]             sum;
  logic [VW-1:0]           delta_ext;
  logic signed [WIDTH:0]   delta_new;
  logic                    last;

  assign sum       = {1'b0, sd_acc_q} + {1'b0, v_q};
  assign delta_ext = VW'(delta_q);
  assign delta_new = $signed({1'b0, buf_q}) - $signed({1'b0, s_cur_q});
  assign last      = (cnt_q == L'(INTERP - 1));

  assign in_ready   = !buf_full_q;
  assign busy       = (state_q == RUN);
  assign frame_tick = busy && last;
  assign pdm_out    = pdm_q;
  assign underrun   = underrun_q;

  // Next-state logic: buffer fill, IDLE/RUN control, sigma-delta step and frame-boundary reload.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    s_cur_d    = s_cur_q;
    v_d        = v_q;
    delta_d    = delta_q;
    sd_acc_d   = sd_acc_q;
    cnt_d      = cnt_q;
    pdm_d      = pdm_q;
    underrun_d = underrun_q;

    // Acceptance only happens while the buffer is empty, so it never collides with consumption below.
    if (in_valid && !buf_full_q) begin
      buf_d      = sample_in;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        pdm_d    = 1'b0;
        cnt_d    = '0;
        sd_acc_d = '0;
        if (en && buf_full_q) begin
          state_d    = RUN;
          s_cur_d    = buf_q;
          v_d        = {buf_q, {L{1'b0}}};
          delta_d    = '0;
          buf_full_d = 1'b0;
        end
      end
      RUN: begin
        if (!en) begin
          // Disable wins over a coincident boundary: no reload, buffer kept for the restart.
          state_d  = IDLE;
          pdm_d    = 1'b0;
          sd_acc_d = '0;
          cnt_d    = '0;
          delta_d  = '0;
        end else begin
          pdm_d    = sum[VW];
          sd_acc_d = sum[VW-1:0];
          v_d      = v_q + delta_ext;
          cnt_d    = cnt_q + L'(1);
          if (last) begin
            // Restart the ramp at the old sample so the next frame slides toward the new one.
            v_d = {s_cur_q, {L{1'b0}}};
            if (buf_full_q) begin
              delta_d    = delta_new;
              s_cur_d    = buf_q;
              buf_full_d = 1'b0;
            end else begin
              delta_d    = '0;
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that also discards any buffered sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      s_cur_q    <= '0;
      v_q        <= '0;
      delta_q    <= '0;
      sd_acc_q   <= '0;
      cnt_q      <= '0;
      pdm_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      s_cur_q    <= s_cur_d;
      v_q        <= v_d;
      delta_q    <= delta_d;
      sd_acc_q   <= sd_acc_d;
      cnt_q      <= cnt_d;
      pdm_q      <= pdm_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Testbench for pdm_modulator (WIDTH=8, INTERP=32).
// Expected PDM bits are pushed to a queue from a behavioural model before each run
// and popped by a monitor on every edge at which the modulator produces a bit.
module tb_pdm_modulator;

  localparam int WIDTH  = 8;
  localparam int INTERP = 32;
  localparam int FULL   = 8192; // 2^(WIDTH+log2(INTERP))

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] sample_in;
  logic             in_valid;
  logic             in_ready;
  logic             pdm_out;
  logic             frame_tick;
  logic             busy;
  logic             underrun;

  pdm_modulator #(.WIDTH(WIDTH), .INTERP(INTERP)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sample_in  (sample_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pdm_out    (pdm_out),
    .frame_tick (frame_tick),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  bit   exp_q[$];
  int   plan[$];
  int   m_sd;
  int   obs_ones;
  bit   mon_en = 1'b0;
  logic run_edge = 1'b0;
  bit   mon_e;

  // A bit is produced on every edge where the modulator is running and enabled.
  always @(posedge clk) run_edge <= busy && en && !rst;

  // Scoreboard: compare each produced bit against the model queue.
  always @(negedge clk) begin
    if (run_edge === 1'b1 && mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pdm_extra_bit: got %b, required no bit at t=%0t", pdm_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (pdm_out !== mon_e)
          $display("FAIL pdm_bit: got %b, required %b at t=%0t", pdm_out, mon_e, $time);
        else
          passed++;
      end
      if (pdm_out === 1'b1) obs_ones++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; sample_in = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Model: push n bits of a constant-v sigma-delta run starting from m_sd.
  task automatic push_bits(input int v, input int n);
    int sum;
    for (int k = 0; k < n; k++) begin
      sum = m_sd + v;
      if (sum >= FULL) begin exp_q.push_back(1'b1); m_sd = sum - FULL; end
      else             begin exp_q.push_back(1'b0); m_sd = sum; end
    end
  endtask

  // Model: push all bits for nframes frames of the sample plan (ramps included).
  task automatic model_plan(input int nframes);
    int s, v, d, sum;
    m_sd = 0; s = plan[0]; v = s * INTERP; d = 0;
    for (int i = 0; i < nframes; i++) begin
      for (int k = 0; k < INTERP; k++) begin
        sum = m_sd + v;
        if (sum >= FULL) begin exp_q.push_back(1'b1); m_sd = sum - FULL; end
        else             begin exp_q.push_back(1'b0); m_sd = sum; end
        v = v + d;
      end
      v = s * INTERP;
      if (i + 1 < plan.size()) begin d = plan[i+1] - s; s = plan[i+1]; end
      else d = 0;
    end
  endtask

  task automatic send_sample(input int x);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("FAIL in_ready_timeout: got %b, required 1", in_ready);
    end
    sample_in = x[WIDTH-1:0];
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Wait (bounded) for frame_tick, then step past the boundary edge.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (frame_tick === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) $display("FAIL frame_tick_timeout: got 0, required 1 within 40 cycles");
    else passed++;
    @(negedge clk);
  endtask

  // Drive a plan: first sample starts RUN, one refill per frame while the plan lasts.
  task automatic run_plan(input int nframes, output bit uf1);
    uf1 = 1'b0;
    model_plan(nframes);
    obs_ones = 0;
    mon_en = 1'b1;
    send_sample(plan[0]);
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < nframes; i++) begin
      if (i + 1 < plan.size()) send_sample(plan[i+1]);
      wait_tick();
      if (i == 0) uf1 = underrun;
    end
    en = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0) $display("FAIL bits_missing: got %0d left over, required 0", exp_q.size());
    else passed++;
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; sample_in = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (pdm_out !== 1'b0)    $display("FAIL rst_pdm: got %b, required 0", pdm_out);    else passed++;
    checks++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b, required 0", busy);      else passed++;
    checks++; if (in_ready !== 1'b1)   $display("FAIL rst_in_ready: got %b, required 1", in_ready); else passed++;
    checks++; if (underrun !== 1'b0)   $display("FAIL rst_underrun: got %b, required 0", underrun); else passed++;
    checks++; if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b, required 0", frame_tick); else passed++;
  endtask

  task automatic test_const128();
    bit uf1;
    do_reset();
    plan = '{128, 128, 128, 128, 128};
    run_plan(4, uf1);
    checks++; if (obs_ones != 64)      $display("FAIL c128_ones: got %0d, required 64", obs_ones); else passed++;
    checks++; if (uf1 !== 1'b0)        $display("FAIL c128_uf1: got %b, required 0", uf1); else passed++;
    checks++; if (underrun !== 1'b0)   $display("FAIL c128_underrun: got %b, required 0", underrun); else passed++;
  endtask

  task automatic test_ramp();
    bit uf1;
    do_reset();
    plan = '{0, 64, 64, 64};
    run_plan(3, uf1);
    checks++; if (obs_ones != 11)      $display("FAIL ramp_ones: got %0d, required 11", obs_ones); else passed++;
    checks++; if (underrun !== 1'b0)   $display("FAIL ramp_underrun: got %b, required 0", underrun); else passed++;
  endtask

  task automatic test_full_scale();
    bit uf1;
    do_reset();
    plan = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    run_plan(8, uf1);
    checks++; if (obs_ones != 255)     $display("FAIL fs_ones: got %0d, required 255", obs_ones); else passed++;
  endtask

  task automatic test_zero();
    bit uf1;
    do_reset();
    plan = '{0, 0, 0};
    run_plan(2, uf1);
    checks++; if (obs_ones != 0)       $display("FAIL zero_ones: got %0d, required 0", obs_ones); else passed++;
  endtask

  task automatic test_underrun();
    bit uf1;
    do_reset();
    plan = '{100};
    run_plan(2, uf1);
    checks++; if (uf1 !== 1'b1)        $display("FAIL ur_after_f1: got %b, required 1", uf1); else passed++;
    checks++; if (obs_ones != 25)      $display("FAIL ur_ones: got %0d, required 25", obs_ones); else passed++;
    checks++; if (in_ready !== 1'b1)   $display("FAIL ur_in_ready: got %b, required 1", in_ready); else passed++;
    checks++; if (underrun !== 1'b1)   $display("FAIL ur_sticky: got %b, required 1", underrun); else passed++;
  endtask

  task automatic test_en_drop();
    bit seen = 1'b0;
    do_reset();
    m_sd = 0;
    push_bits(3200, 10);
    obs_ones = 0;
    mon_en = 1'b1;
    send_sample(100);
    en = 1'b1;
    @(negedge clk);            // cnt = 0
    send_sample(200);          // cnt = 1, buffered
    repeat (9) @(negedge clk); // cnt = 10
    en = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)       $display("FAIL drop_busy: got %b, required 0", busy); else passed++;
    checks++; if (pdm_out !== 1'b0)    $display("FAIL drop_pdm: got %b, required 0", pdm_out); else passed++;
    checks++; if (frame_tick !== 1'b0) $display("FAIL drop_tick: got %b, required 0", frame_tick); else passed++;
    checks++; if (in_ready !== 1'b0)   $display("FAIL drop_buf_kept: got %b, required 0", in_ready); else passed++;
    // Restart from the retained sample with a flat ramp; disable again on the boundary cycle.
    m_sd = 0;
    push_bits(6400, 31);
    en = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1)       $display("FAIL restart_busy: got %b, required 1", busy); else passed++;
    checks++; if (in_ready !== 1'b1)   $display("FAIL restart_in_ready: got %b, required 1", in_ready); else passed++;
    for (int n = 0; n < 40; n++) begin
      if (frame_tick === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) $display("FAIL restart_tick: got 0, required 1 within 40 cycles"); else passed++;
    en = 1'b0;
    @(negedge clk);
    checks++; if (underrun !== 1'b0)   $display("FAIL drop_at_boundary_underrun: got %b, required 0", underrun); else passed++;
    @(negedge clk);
    checks++; if (exp_q.size() != 0)   $display("FAIL drop_bits_missing: got %0d left, required 0", exp_q.size()); else passed++;
    checks++; if (obs_ones != 27)      $display("FAIL drop_ones: got %0d, required 27", obs_ones); else passed++;
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    mon_en = 1'b0;
    send_sample(50);
    en = 1'b1;
    @(negedge clk);
    wait_tick();               // boundary with empty buffer sets underrun
    send_sample(60);           // buffered
    repeat (5) @(negedge clk);
    checks++; if (underrun !== 1'b1)   $display("FAIL pre_rst_underrun: got %b, required 1", underrun); else passed++;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (pdm_out !== 1'b0)    $display("FAIL mrst_pdm: got %b, required 0", pdm_out); else passed++;
    checks++; if (busy !== 1'b0)       $display("FAIL mrst_busy: got %b, required 0", busy); else passed++;
    checks++; if (in_ready !== 1'b1)   $display("FAIL mrst_in_ready: got %b, required 1", in_ready); else passed++;
    checks++; if (underrun !== 1'b0)   $display("FAIL mrst_underrun: got %b, required 0", underrun); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0)       $display("FAIL mrst_no_restart: got %b, required 0", busy); else passed++;
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; sample_in = '0;
    test_reset();
    test_const128();
    test_ramp();
    test_full_scale();
    test_zero();
    test_underrun();
    test_en_drop();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
